// File: rtl/seg_scan_ctrl.sv
// Score display controller: sequential binary-to-BCD conversion feeding a
// time-multiplexed 4-digit 7-segment scan with leading-zero blanking.
module seg_scan_ctrl #(
   parameter int BIN_W    = 14,
   parameter int SCAN_DIV = 10000,
   parameter int BLANK_LZ = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [BIN_W-1:0] value_in,
   output logic             busy,
   output logic             done,
   output logic [3:0]       bcd_digit,
   output logic [3:0]       digit_com,
   output logic             seg_blank
);

   localparam int CW = $clog2(BIN_W + 1);
   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

   state_t           state_q, state_d;
   logic [BIN_W-1:0] bin_q, bin_d, sat;
   logic [15:0]      acc_q, acc_d, adj;
   logic [15:0]      disp_q, disp_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [PW-1:0]    pre_q, pre_d;
   logic [1:0]       idx_q, idx_d;
   logic [3:0]       com_q, com_d;
   logic [3:0]       dig_q, dig_d;
   logic             blank_q, blank_d;
   logic             wrap;

   always_comb begin
      sat = value_in;
      if (32'(value_in) > 32'd9999) sat = BIN_W'(9999);
   end

   // Double-dabble correction applied before every shift
   always_comb begin
      adj = acc_q;
      for (int k = 0; k < 4; k++) begin
         if (acc_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
      end
   end

   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      disp_d  = disp_q;
      case (state_q)
         IDLE: begin
            if (load) begin
               bin_d   = sat;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            {acc_d, bin_d} = {adj, bin_q} << 1;
            cnt_d = cnt_q + 1'b1;
            // Display is written on the final shift so it is valid with done
            if (cnt_q == CW'(BIN_W - 1)) begin
               disp_d  = acc_d;
               state_d = LATCH;
            end
         end
         LATCH:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign wrap  = (pre_q == PW'(SCAN_DIV - 1));
   assign pre_d = wrap ? '0 : pre_q + 1'b1;
   assign idx_d = wrap ? idx_q + 2'd1 : idx_q;
   assign com_d = ~(4'b0001 << idx_q);
   assign dig_d = disp_q[{idx_q, 2'b00} +: 4];

   always_comb begin
      blank_d = 1'b0;
      case (idx_q)
         2'd1:    blank_d = (disp_q[15:4] == 12'd0);
         2'd2:    blank_d = (disp_q[15:8] == 8'd0);
         2'd3:    blank_d = (disp_q[15:12] == 4'd0);
         default: blank_d = 1'b0;
      endcase
      if (BLANK_LZ == 0) blank_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         bin_q   <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         disp_q  <= '0;
         pre_q   <= '0;
         idx_q   <= '0;
         com_q   <= 4'b1110;
         dig_q   <= '0;
         blank_q <= 1'b0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         disp_q  <= disp_d;
         pre_q   <= pre_d;
         idx_q   <= idx_d;
         com_q   <= com_d;
         dig_q   <= dig_d;
         blank_q <= blank_d;
      end
   end

   assign busy      = (state_q != IDLE);
   assign done      = (state_q == LATCH);
   assign digit_com = com_q;
   assign bcd_digit = dig_q;
   assign seg_blank = blank_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: loads queue expected BCD/blank
// patterns; a done-driven monitor checks latency and scanned digits.
module tb_seg_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        load = 1'b0;
   logic [13:0] value_in = '0;
   logic        busy, done, seg_blank;
   logic [3:0]  bcd_digit, digit_com;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   typedef struct {
      int          t;
      logic [15:0] bcd;
      logic [3:0]  blk;
   } exp_t;

   exp_t q[$];
   exp_t e;

   seg_scan_ctrl #(.BIN_W(14), .SCAN_DIV(4), .BLANK_LZ(1)) dut (
      .clk(clk), .rst_n(rst_n), .load(load), .value_in(value_in),
      .busy(busy), .done(done), .bcd_digit(bcd_digit),
      .digit_com(digit_com), .seg_blank(seg_blank)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, req, cyc);
      end
   endtask

   // Observe 16 scan cycles and collect each position once
   task automatic read_disp(input logic [15:0] bcd, input logic [3:0] blk);
      logic [3:0] d[4];
      logic       b[4];
      bit         seen[4];
      int         p;
      for (int k = 0; k < 4; k++) begin
         seen[k] = 0;
         d[k] = '0;
         b[k] = 1'b0;
      end
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         case (digit_com)
            4'b1110: p = 0;
            4'b1101: p = 1;
            4'b1011: p = 2;
            4'b0111: p = 3;
            default: p = -1;
         endcase
         if (p < 0) chk("common_onehot", int'(digit_com), 4'b1110);
         else if (!seen[p]) begin
            seen[p] = 1;
            d[p] = bcd_digit;
            b[p] = seg_blank;
         end
      end
      for (int k = 0; k < 4; k++)
         chk($sformatf("disp%0d_of_%h", k, bcd),
             seen[k] ? int'({b[k], d[k]}) : -1,
             int'({blk[k], bcd[4*k +: 4]}));
   endtask

   // Scoreboard monitor: busy window, done latency, displayed value
   always @(negedge clk) begin
      if (rst_n) begin
         chk("busy", int'(busy),
             int'(q.size() > 0 && cyc >= q[0].t + 1 && cyc <= q[0].t + 15));
         if (done) begin
            if (q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
               e = q.pop_front();
               chk("done_latency", cyc - e.t, 15);
               fork
                  read_disp(e.bcd, e.blk);
               join_none
            end
         end else if (q.size() > 0 && cyc > q[0].t + 15) begin
            chk("done_timeout", 0, 1);
            void'(q.pop_front());
         end
      end
   end

   // Scan rhythm: each common held 4 cycles, then rotates to next digit
   logic [3:0] prev_com;
   int         run = 0;
   bit         first = 1;
   always @(negedge clk) begin
      if (!rst_n) begin
         first = 1;
         run = 0;
         prev_com = digit_com;
      end else if (digit_com != prev_com) begin
         if (!first) begin
            chk("scan_hold", run, 4);
            chk("scan_next", int'(digit_com), int'({prev_com[2:0], prev_com[3]}));
         end
         first = 0;
         prev_com = digit_com;
         run = 1;
      end else run++;
   end

   task automatic reset_vals(input string tag);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_com"}, int'(digit_com), 4'b1110);
      chk({tag, "_bcd"}, int'(bcd_digit), 0);
      chk({tag, "_blank"}, int'(seg_blank), 0);
   endtask

   task automatic do_load(input int v, input logic [15:0] b, input logic [3:0] k);
      @(negedge clk);
      load = 1'b1;
      value_in = v[13:0];
      q.push_back('{t: cyc, bcd: b, blk: k});
      @(negedge clk);
      load = 1'b0;
      repeat (34) @(negedge clk);
   endtask

   int t0;

   initial begin
      @(negedge clk);
      reset_vals("por");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      do_load(1234, 16'h1234, 4'b0000);
      do_load(10000, 16'h9999, 4'b0000);
      do_load(16383, 16'h9999, 4'b0000);
      do_load(0, 16'h0000, 4'b1110);
      do_load(7, 16'h0007, 4'b1110);
      do_load(1005, 16'h1005, 4'b0000);

      // Loads during SHIFT and LATCH are dropped; the next one is taken
      @(negedge clk);
      t0 = cyc;
      load = 1'b1;
      value_in = 14'd42;
      q.push_back('{t: t0, bcd: 16'h0042, blk: 4'b1100});
      @(negedge clk);
      load = 1'b0;
      while (cyc < t0 + 5) @(negedge clk);
      load = 1'b1;
      value_in = 14'd77;
      @(negedge clk);
      load = 1'b0;
      while (cyc < t0 + 15) @(negedge clk);
      load = 1'b1;
      @(negedge clk);
      q.push_back('{t: cyc, bcd: 16'h0077, blk: 4'b1100});
      @(negedge clk);
      load = 1'b0;
      repeat (34) @(negedge clk);

      // Asynchronous reset mid-cycle while a nonzero digit is lit
      for (int i = 0; i < 16; i++) begin
         if (digit_com != 4'b1110 && bcd_digit != 4'd0) break;
         @(negedge clk);
      end
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 reset_vals("async");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Reset in the middle of a conversion aborts it
      @(negedge clk);
      t0 = cyc;
      load = 1'b1;
      value_in = 14'd8888;
      q.push_back('{t: t0, bcd: 16'h8888, blk: 4'b0000});
      @(negedge clk);
      load = 1'b0;
      while (cyc < t0 + 8) @(negedge clk);
      #2 rst_n = 1'b0;
      q.delete();
      @(negedge clk);
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      @(negedge clk);
      rst_n = 1'b1;
      read_disp(16'h0000, 4'b1110);
      do_load(555, 16'h0555, 4'b1000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
